// File: rtl/m_cycle_sequencer.sv
// m_cycle_sequencer: T-state / M-cycle timing generator for the CPU control unit.
// o_Cycle_Step is a one-hot T-state and o_Cycle_Count a one-hot M-cycle index.
// Instruction boundaries come from the microcode's IR_Fetch, or from BOOT after reset.
// Also handles stall, HALT entry/wake, and a sticky overrun error.
// Optional feature macro: SEQ_SINGLE_STEP_EN adds a PAUSE state.
// While paused, the sequencer waits at each RUN boundary for i_Step_Req.
module m_cycle_sequencer #(
    parameter int unsigned STEPS      = 4,
    parameter int unsigned MAX_CYCLES = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_Stall,
    input  logic                  i_IR_Fetch,
    input  logic                  i_Halt_Req,
    input  logic                  i_Wake,
    input  logic                  i_Step_Req,
    output logic [STEPS-1:0]      o_Cycle_Step,
    output logic [MAX_CYCLES-1:0] o_Cycle_Count,
    output logic                  o_Boot_Fetch,
    output logic                  o_Opcode_Latch,
    output logic                  o_Halted,
    output logic                  o_Seq_Error
);

    localparam logic [STEPS-1:0]      STEP_T1     = STEPS'(1);
    localparam logic [MAX_CYCLES-1:0] COUNT_FIRST = MAX_CYCLES'(1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [STEPS-1:0]        step_q, step_d;
    logic [MAX_CYCLES-1:0]   count_q, count_d;
    logic                    latch_q, latch_d;
    logic                    err_q, err_d;

    logic t4_end;
    logic boundary;

`ifndef SEQ_SINGLE_STEP_EN
    logic unused_step_req;
    assign unused_step_req = i_Step_Req;
`endif

    // An unstalled T4 edge ends the M-cycle; it is an instruction boundary on a fetch or in BOOT.
    assign t4_end   = step_q[STEPS-1] & ~i_Stall;
    assign boundary = t4_end & (i_IR_Fetch | (state_q == S_BOOT));

    // Registered sequencer state with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_BOOT;
            step_q  <= STEP_T1;
            count_q <= '0;
            latch_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            count_q <= count_d;
            latch_q <= latch_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: T-state rotation, M-cycle advance, and boundary/halt handling.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        latch_d = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            S_BOOT: begin
                if (!i_Stall) begin
                    step_d = {step_q[STEPS-2:0], step_q[STEPS-1]};
                end
                if (boundary) begin
                    state_d = S_RUN;
                    count_d = COUNT_FIRST;
                    latch_d = 1'b1;
                end
            end
            S_RUN: begin
                if (!i_Stall) begin
                    step_d = {step_q[STEPS-2:0], step_q[STEPS-1]};
                end
                if (boundary) begin
                    count_d = COUNT_FIRST;
                    if (i_Halt_Req && !i_Wake) begin
                        state_d = S_HALT;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state_d = S_PAUSE;
`else
                        latch_d = 1'b1;
`endif
                    end
                end else if (t4_end) begin
                    // Overrun: freeze the index at the last M-cycle, flag it, keep stepping.
                    if (count_q[MAX_CYCLES-1]) begin
                        err_d = 1'b1;
                    end else begin
                        count_d = {count_q[MAX_CYCLES-2:0], 1'b0};
                    end
                end
            end
            S_HALT: begin
                step_d  = STEP_T1;
                count_d = COUNT_FIRST;
                if (i_Wake) begin
                    state_d = S_RUN;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                step_d  = STEP_T1;
                count_d = COUNT_FIRST;
                if (i_Step_Req) begin
                    state_d = S_RUN;
                    latch_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_BOOT;
                step_d  = STEP_T1;
                count_d = '0;
            end
        endcase
    end

    assign o_Cycle_Step   = step_q;
    assign o_Cycle_Count  = count_q;
    assign o_Boot_Fetch   = (state_q == S_BOOT);
    assign o_Opcode_Latch = latch_q;
    assign o_Halted       = (state_q == S_HALT);
    assign o_Seq_Error    = err_q;

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// Directed testbench for m_cycle_sequencer in the default build.
// This build has no single-step, so SEQ_SINGLE_STEP_EN is undefined.
module tb_m_cycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic       irf = 1'b0;
    logic       hreq = 1'b0;
    logic       wake = 1'b0;
    logic       sreq = 1'b0;
    logic [3:0] step;
    logic [7:0] count;
    logic       boot, latch, halted, err;
    logic [15:0] st;
    logic [15:0] exp_st;
    int nvec = 0;
    int nerr = 0;

    // Status vector layout: {step[3:0], count[7:0], boot, latch, halted, err}.
    assign st = {step, count, boot, latch, halted, err};

    always #5 clk = ~clk;

    m_cycle_sequencer #(.STEPS(4), .MAX_CYCLES(8)) dut (
        .i_Clk          (clk),
        .i_Reset_n      (rst_n),
        .i_Stall        (stall),
        .i_IR_Fetch     (irf),
        .i_Halt_Req     (hreq),
        .i_Wake         (wake),
        .i_Step_Req     (sreq),
        .o_Cycle_Step   (step),
        .o_Cycle_Count  (count),
        .o_Boot_Fetch   (boot),
        .o_Opcode_Latch (latch),
        .o_Halted       (halted),
        .o_Seq_Error    (err)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        exp_st = {4'b0001, 8'h00, 4'b1000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL reset: got %h want %h", st, exp_st); end
        rst_n = 1'b1;
    endtask

    task automatic test_boot();
        logic [3:0] es;
        for (int i = 0; i < 4; i++) begin
            es = 4'b0001 << i;
            exp_st = {es, 8'h00, 4'b1000};
            nvec++;
            if (st !== exp_st) begin nerr++; $display("FAIL boot_t%0d: got %h want %h", i + 1, st, exp_st); end
            tick(1);
        end
        exp_st = {4'b0001, 8'h01, 4'b0100};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL boot_exit: got %h want %h", st, exp_st); end
        tick(1);
        exp_st = {4'b0010, 8'h01, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL latch_one_clk: got %h want %h", st, exp_st); end
        tick(2);
    endtask

    task automatic test_fetch_restart();
        tick(1);
        exp_st = {4'b0001, 8'h02, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL m2_start: got %h want %h", st, exp_st); end
        tick(4);
        exp_st = {4'b0001, 8'h04, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL m3_start: got %h want %h", st, exp_st); end
        irf = 1'b1;
        tick(3);
        exp_st = {4'b1000, 8'h04, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL m3_t4: got %h want %h", st, exp_st); end
        tick(1);
        exp_st = {4'b0001, 8'h01, 4'b0100};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL fetch_restart: got %h want %h", st, exp_st); end
        irf = 1'b0;
    endtask

    task automatic test_stall();
        tick(5);
        exp_st = {4'b0010, 8'h02, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL m2_t2: got %h want %h", st, exp_st); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            nvec++;
            if (st !== exp_st) begin nerr++; $display("FAIL stall_hold%0d: got %h want %h", i, st, exp_st); end
        end
        stall = 1'b0;
        tick(1);
        exp_st = {4'b0100, 8'h02, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL stall_resume: got %h want %h", st, exp_st); end
        tick(1);
        stall = 1'b1;
        irf = 1'b1;
        tick(1);
        exp_st = {4'b1000, 8'h02, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL stall_boundary: got %h want %h", st, exp_st); end
        stall = 1'b0;
        tick(1);
        exp_st = {4'b0001, 8'h01, 4'b0100};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL stall_then_fetch: got %h want %h", st, exp_st); end
        irf = 1'b0;
        stall = 1'b1;
        tick(1);
        exp_st = {4'b0001, 8'h01, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL latch_stalled_t1: got %h want %h", st, exp_st); end
        stall = 1'b0;
    endtask

    task automatic test_halt();
        tick(3);
        hreq = 1'b1;
        irf = 1'b1;
        tick(1);
        exp_st = {4'b0001, 8'h01, 4'b0010};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL halt_enter: got %h want %h", st, exp_st); end
        hreq = 1'b0;
        irf = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            nvec++;
            if (st !== exp_st) begin nerr++; $display("FAIL halt_hold%0d: got %h want %h", i, st, exp_st); end
        end
        stall = 1'b0;
        wake = 1'b1;
        tick(1);
        exp_st = {4'b0001, 8'h01, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL wake: got %h want %h", st, exp_st); end
        wake = 1'b0;
        tick(1);
        exp_st = {4'b0010, 8'h01, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL wake_t2: got %h want %h", st, exp_st); end
        tick(2);
        irf = 1'b1;
        hreq = 1'b1;
        wake = 1'b1;
        tick(1);
        exp_st = {4'b0001, 8'h01, 4'b0100};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL halt_wake_same: got %h want %h", st, exp_st); end
        irf = 1'b0;
        wake = 1'b0;
        tick(2);
        exp_st = {4'b0100, 8'h01, 4'b0000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL halt_req_midcycle: got %h want %h", st, exp_st); end
        hreq = 1'b0;
        tick(2);
    endtask

    task automatic test_seq_error();
        logic [7:0] ec;
        for (int m = 1; m < 8; m++) begin
            ec = 8'h01 << m;
            exp_st = {4'b0001, ec, 4'b0000};
            nvec++;
            if (st !== exp_st) begin nerr++; $display("FAIL count_m%0d: got %h want %h", m + 1, st, exp_st); end
            tick(4);
        end
        exp_st = {4'b0001, 8'h80, 4'b0001};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL seq_error: got %h want %h", st, exp_st); end
        tick(4);
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL error_hold: got %h want %h", st, exp_st); end
        irf = 1'b1;
        tick(4);
        exp_st = {4'b0001, 8'h01, 4'b0101};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL error_sticky: got %h want %h", st, exp_st); end
        irf = 1'b0;
        tick(5);
        exp_st = {4'b0010, 8'h02, 4'b0001};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL pre_reset_m2: got %h want %h", st, exp_st); end
        rst_n = 1'b0;
        #1;
        exp_st = {4'b0001, 8'h00, 4'b1000};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL async_reset: got %h want %h", st, exp_st); end
        tick(1);
        rst_n = 1'b1;
        tick(4);
        exp_st = {4'b0001, 8'h01, 4'b0100};
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL reboot: got %h want %h", st, exp_st); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_boot();
        test_fetch_restart();
        test_stall();
        test_halt();
        test_seq_error();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
